// File: rtl/onehot_scan_encoder_32x5.sv
// Scanning encoder: accepts an N-bit line vector and returns the W-bit index of
// every set bit, one per output beat, lowest-first or highest-first.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is high only in IDLE. out_valid is high only in EMIT.
// While out_valid=1 and out_ready=0 the beat fields hold. No output depends
// combinationally on any input.
module onehot_scan_encoder_32x5 #(
    parameter int N         = 32,
    parameter int W         = 5,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state_q;
    logic [N-1:0]   pend_q;
    logic           zero_flag_q;

    logic [W-1:0]   sel_idx;
    logic           pend_one_hot;
    logic [N-1:0]   pend_d;

    // The last hit in the scan wins, so the scan direction picks the priority.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend_q[i]) sel_idx = W'(i);
            end
        end
    end

    always_comb begin
        pend_one_hot = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
        pend_d       = pend_q & ~(N'(1) << sel_idx);
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_none  = out_valid & zero_flag_q;
        out_last  = out_valid & (zero_flag_q | pend_one_hot);
        out_idx   = (out_valid && !zero_flag_q) ? sel_idx : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pend_q      <= in_vec;
                        zero_flag_q <= (in_vec == '0);
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            pend_q      <= '0;
                            zero_flag_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            pend_q <= pend_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_scan_encoder_32x5.sv
// Directed bench for onehot_scan_encoder_32x5: both scan orders run side by side
// against a beat-list model, plus literal checks on the recorded beat streams.
module tb_onehot_scan_encoder_32x5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_vec;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, out_last_l, out_none_l;
    logic [4:0]  out_idx_l;
    logic        in_ready_m, out_valid_m, out_last_m, out_none_m;
    logic [4:0]  out_idx_m;

    int checks   = 0;
    int failures = 0;

    // Beat encoding: {none, last, idx[4:0]}
    logic [6:0] exp_q_l[$];
    logic [6:0] exp_q_m[$];
    logic [6:0] log_l[$];
    logic [6:0] log_m[$];
    bit         busy = 1'b0;
    int         busy_cycles = 0;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    onehot_scan_encoder_32x5 #(.N(32), .W(5), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_l), .out_idx(out_idx_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .out_last(out_last_l), .out_none(out_none_l)
    );

    onehot_scan_encoder_32x5 #(.N(32), .W(5), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_m), .out_idx(out_idx_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .out_last(out_last_m), .out_none(out_none_m)
    );

    // Expected beat list for a vector: every set index in order, last flag on the final one.
    task automatic load_model(input logic [31:0] v);
        int k;
        int n;
        k = $countones(v);
        if (v == 32'h0) begin
            exp_q_l.push_back(7'b11_00000);
            exp_q_m.push_back(7'b11_00000);
        end else begin
            n = 0;
            for (int i = 0; i < 32; i++) begin
                if (v[i]) begin
                    n++;
                    exp_q_l.push_back({1'b0, (n == k), 5'(i)});
                end
            end
            n = 0;
            for (int i = 31; i >= 0; i--) begin
                if (v[i]) begin
                    n++;
                    exp_q_m.push_back({1'b0, (n == k), 5'(i)});
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q_l.delete();
            exp_q_m.delete();
            busy = 1'b0;
        end else if (busy) begin
            busy_cycles++;
            if (out_ready) begin
                log_l.push_back({out_none_l, out_last_l, out_idx_l});
                log_m.push_back({out_none_m, out_last_m, out_idx_m});
                void'(exp_q_l.pop_front());
                void'(exp_q_m.pop_front());
                if (exp_q_l.size() == 0) busy = 1'b0;
            end
        end else if (in_valid) begin
            load_model(in_vec);
            busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] want_l, want_m, got_l, got_m;
        if (chk_en) begin
            want_l = {!busy, busy, busy ? exp_q_l[0] : 7'h00};
            want_m = {!busy, busy, busy ? exp_q_m[0] : 7'h00};
            got_l  = {in_ready_l, out_valid_l, out_none_l, out_last_l, out_idx_l};
            got_m  = {in_ready_m, out_valid_m, out_none_m, out_last_m, out_idx_m};
            checks += 2;
            if (got_l !== want_l) begin
                failures++;
                $display("FAIL cyc_lsb t=%0t {rdy,vld,none,last,idx} got=%b want=%b", $time, got_l, want_l);
            end
            if (got_m !== want_m) begin
                failures++;
                $display("FAIL cyc_msb t=%0t {rdy,vld,none,last,idx} got=%b want=%b", $time, got_m, want_m);
            end
        end
    end

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_vec   = $urandom();
    endtask

    task automatic drain(input bit toggle, input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            @(posedge clk);
            #2;
            c++;
        end
        out_ready = 1'b0;
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL drain_timeout got=%0d want<%0d", c, limit);
        end
    endtask

    task automatic clear_logs();
        log_l.delete();
        log_m.delete();
        busy_cycles = 0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        rst    = 1'b0;
        check_val("rst_in_ready", int'(in_ready_l), 1);
        check_val("rst_out_valid", int'(out_valid_l), 0);
        check_val("rst_idx_last_none", int'({out_idx_m, out_last_m, out_none_m}), 0);
        repeat (2) @(posedge clk);
        #2;

        // Three sparse bits, downstream always ready.
        clear_logs();
        send(32'h8000_0011);
        drain(1'b0, 20);
        check_val("t2_count", log_l.size(), 3);
        check_val("t2_b0", int'(log_l[0]), 7'h00);
        check_val("t2_b1", int'(log_l[1]), 7'h04);
        check_val("t2_b2", int'(log_l[2]), 7'b01_11111);
        check_val("t2_cycles", busy_cycles, 3);
        check_val("t2_ready_after", int'(in_ready_l), 1);

        // All-zero vector: one none beat.
        clear_logs();
        send(32'h0);
        drain(1'b0, 20);
        check_val("t3_count", log_l.size(), 1);
        check_val("t3_lsb", int'(log_l[0]), 7'b11_00000);
        check_val("t3_msb", int'(log_m[0]), 7'b11_00000);

        // Full vector with backpressure every other cycle.
        clear_logs();
        send(32'hFFFF_FFFF);
        drain(1'b1, 200);
        check_val("t4_count", log_m.size(), 32);
        check_val("t4_cycles", busy_cycles, 63);
        for (int i = 0; i < 32 && i < log_m.size(); i++) begin
            check_val($sformatf("t4_msb_%0d", i), int'(log_m[i]), int'({1'b0, (i == 31), 5'(31 - i)}));
            check_val($sformatf("t4_lsb_%0d", i), int'(log_l[i]), int'({1'b0, (i == 31), 5'(i)}));
        end

        // Round trip through a 5-to-32 decoder output.
        for (int a = 0; a < 32; a++) begin
            logic [31:0] dec;
            dec = 32'd1 << a;
            clear_logs();
            send(dec);
            drain(1'b0, 10);
            check_val($sformatf("rt_n_%0d", a), log_l.size(), 1);
            if (log_l.size() == 1 && log_m.size() == 1) begin
                check_val($sformatf("rt_lsb_%0d", a), int'(log_l[0]), int'({2'b01, 5'(a)}));
                check_val($sformatf("rt_msb_%0d", a), int'(log_m[0]), int'({2'b01, 5'(a)}));
            end
        end

        // Reset after the first beat discards the rest.
        clear_logs();
        send(32'h0000_00F0);
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_val("t6_valid_l", int'(out_valid_l), 0);
        check_val("t6_ready_l", int'(in_ready_l), 1);
        check_val("t6_valid_m", int'(out_valid_m), 0);
        repeat (5) @(posedge clk);
        #2;
        out_ready = 1'b0;
        check_val("t6_count", log_l.size(), 1);
        check_val("t6_lsb", int'(log_l[0]), 7'h04);
        check_val("t6_msb", int'(log_m[0]), 7'h07);

        // Encoder still usable after the mid-stream reset.
        clear_logs();
        send(32'h0000_0300);
        drain(1'b0, 10);
        check_val("t7_count", log_l.size(), 2);
        check_val("t7_b0", int'(log_l[0]), 7'h08);
        check_val("t7_b1", int'(log_l[1]), 7'b01_01001);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
